// File: rtl/regfile_dump_if.sv
// Bundles the dump sequencer's register-file read port, UART TX byte stream and status lines.
// The master side is the sequencer. The slave side is the core/regfile/UART environment.
interface regfile_dump_if #(
    parameter int ADDR_W = 5
) ();
    logic              start;
    logic [ADDR_W-1:0] rd_address;
    logic [31:0]       rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              halt_req;
    logic              done;

    modport master (
        input  start, rd_data, tx_ready,
        output rd_address, tx_data, tx_valid, busy, halt_req, done
    );

    modport slave (
        output start, rd_data, tx_ready,
        input  rd_address, tx_data, tx_valid, busy, halt_req, done
    );
endinterface

// File: rtl/regfile_dump_sequencer.sv
// Debug dumper: walks the integer register file through one read port and streams each
// 32-bit value MSB-first as bytes to the UART TX interface, holding the core while busy.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start; read address parked at 0
//   S_HEADER | offering the sync byte until the transmitter takes it
//   S_FETCH  | one cycle: capture rd_data for reg_idx into the shift register
//   S_SEND   | offering shift_reg[31:24]; each accepted byte shifts left by 8
//   S_DONE   | one-cycle done pulse, still busy, then back to idle
module regfile_dump_sequencer #(
    parameter int         NUM_REGS    = 32,
    parameter int         ADDR_W      = 5,
    parameter bit         SEND_HEADER = 1'b1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic           clk,
    input  logic           reset,
    regfile_dump_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] reg_idx;
    logic [31:0]       shift_reg;
    logic [1:0]        byte_cnt;
    logic              tx_valid_c;
    logic [7:0]        tx_data_c;
    logic              busy_c;
    logic              done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    state_nxt = SEND_HEADER ? S_HEADER : S_FETCH;
                end
            end
            S_HEADER: begin
                tx_valid_c = 1'b1;
                tx_data_c  = HEADER_BYTE;
                if (bus.tx_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                tx_valid_c = 1'b1;
                tx_data_c  = shift_reg[31:24];
                if (bus.tx_ready && (byte_cnt == 2'd3)) begin
                    state_nxt = (reg_idx == LAST_IDX) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy_c    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // reg_idx doubles as the read address, so it is parked at 0 whenever idle
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_idx   <= '0;
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    reg_idx <= '0;
                end
                S_FETCH: begin
                    shift_reg <= bus.rd_data;
                    byte_cnt  <= '0;
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        shift_reg <= {shift_reg[23:0], 8'h00};
                        if (byte_cnt != 2'd3) begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end else if (reg_idx != LAST_IDX) begin
                            reg_idx <= reg_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    reg_idx <= '0;
                end
                default: begin
                    reg_idx <= '0;
                end
            endcase
        end
    end

    assign bus.rd_address = reg_idx;
    assign bus.tx_valid   = tx_valid_c;
    assign bus.tx_data    = tx_data_c;
    assign bus.busy       = busy_c;
    assign bus.halt_req   = busy_c;
    assign bus.done       = done_c;
endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Directed bench for regfile_dump_sequencer: a default 32-register instance with header,
// and a 4-register instance without header, both fed from small register-file models.
module tb_regfile_dump_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    regfile_dump_if #(.ADDR_W(5)) bus_a ();
    regfile_dump_if #(.ADDR_W(5)) bus_b ();

    regfile_dump_sequencer dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_dump_sequencer #(
        .NUM_REGS    (4),
        .ADDR_W      (5),
        .SEND_HEADER (1'b0),
        .HEADER_BYTE (8'hA5)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic [31:0] regs_a [32];
    logic [31:0] regs_b [32];
    logic        garbage_en = 1'b0;
    logic        rand_ready = 1'b0;
    logic        ready_level = 1'b1;

    // Garbage is presented whenever the dumper is not in its fetch cycle.
    assign bus_a.rd_data = (garbage_en && !(bus_a.busy && !bus_a.tx_valid))
                           ? (32'hBAD0_0000 | 32'(cyc)) : regs_a[bus_a.rd_address];
    assign bus_b.rd_data = regs_b[bus_b.rd_address];

    always @(posedge clk) begin
        #1;
        bus_a.tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_level;
    end

    logic [7:0] bytes_a [$];
    logic [7:0] bytes_b [$];
    logic [4:0] addr_seq [$];
    int         done_cnt_a = 0;
    int         done_cyc_a = 0;
    int         done_cnt_b = 0;
    int         done_cyc_b = 0;
    int         hold_err_a = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus_a.tx_valid || bus_a.tx_data != prev_data)) hold_err_a++;
            if (bus_a.tx_valid && bus_a.tx_ready) bytes_a.push_back(bus_a.tx_data);
            if (bus_a.busy && !bus_a.tx_valid && !bus_a.done) addr_seq.push_back(bus_a.rd_address);
            if (bus_a.done) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            prev_stall = bus_a.tx_valid && !bus_a.tx_ready;
            prev_data  = bus_a.tx_data;
            if (bus_b.tx_valid && bus_b.tx_ready) bytes_b.push_back(bus_b.tx_data);
            if (bus_b.done) begin
                done_cnt_b++;
                done_cyc_b = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        bus_a.start = 1'b1;
        tick(1);
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int base, input int budget, input string tag);
        int n = 0;
        while (((use_b ? done_cnt_b : done_cnt_a) == base) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'((use_b ? done_cnt_b : done_cnt_a) != base), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int base);
        int n = bytes_a.size() - base;
        chk({tag, "_count"}, 32'(n), 32'd129);
        if (n > 0) chk({tag, "_hdr"}, 32'(bytes_a[base]), 32'h0000_00A5);
        for (int j = 0; j < 128; j++) begin
            logic [31:0] w;
            logic [7:0]  e;
            w = regs_a[j / 4];
            e = 8'(w >> (8 * (3 - (j % 4))));
            if (j + 1 < n) chk($sformatf("%s_byte%0d", tag, j + 1), 32'(bytes_a[base + j + 1]), 32'(e));
        end
    endtask

    logic [7:0] t1_head [13] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33,
                                 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int bb;
        int bd;
        int bh;
        int ba;
        logic busy_in_done;
        logic busy_after;

        for (int i = 0; i < 32; i++) begin
            regs_a[i] = 32'h0;
            regs_b[i] = 32'h0;
        end
        regs_a[1] = 32'h1122_3344;
        regs_a[2] = 32'hDEAD_BEEF;
        regs_b[3] = 32'h0000_00FF;
        bus_a.start  = 1'b0;
        bus_b.start  = 1'b0;
        bus_b.tx_ready = 1'b1;

        // reset state, with start held during reset
        tick(2);
        bus_a.start = 1'b1;
        tick(1);
        bus_a.start = 1'b0;
        chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("rst_busy",     32'(bus_a.busy), 32'd0);
        chk("rst_halt",     32'(bus_a.halt_req), 32'd0);
        chk("rst_done",     32'(bus_a.done), 32'd0);
        chk("rst_addr",     32'(bus_a.rd_address), 32'd0);
        chk("rst_tx_data",  32'(bus_a.tx_data), 32'd0);
        reset = 1'b0;
        tick(2);
        chk("rst_start_ignored", 32'(bus_a.busy), 32'd0);

        // T1: ready held high
        bb = bytes_a.size(); bd = done_cnt_a; s0 = cyc;
        pulse_start_a();
        wait_done(1'b0, bd, 400, "t1_done_seen");
        chk("t1_done_cyc", 32'(done_cyc_a - s0), 32'd162);
        chk("t1_busy_in_done", 32'(bus_a.busy), 32'd1);
        for (int i = 0; i < 13; i++) chk($sformatf("t1_head%0d", i), 32'(bytes_a[bb + i]), 32'(t1_head[i]));
        check_stream("t1", bb);
        tick(1);
        chk("t1_busy_after", 32'(bus_a.busy), 32'd0);
        tick(3);

        // T2: ready at ~30% duty
        bb = bytes_a.size(); bd = done_cnt_a; bh = hold_err_a;
        rand_ready = 1'b1;
        pulse_start_a();
        wait_done(1'b0, bd, 4000, "t2_done_seen");
        rand_ready = 1'b0;
        tick(4);
        check_stream("t2", bb);
        chk("t2_hold", 32'(hold_err_a - bh), 32'd0);
        chk("t2_done_once", 32'(done_cnt_a - bd), 32'd1);

        // T3: start pulses while busy, including during the done cycle
        bb = bytes_a.size(); bd = done_cnt_a; s0 = cyc;
        busy_in_done = 1'b0; busy_after = 1'b1;
        pulse_start_a();
        while (cyc < s0 + 170) begin
            bus_a.start = (cyc == s0 + 10) || (cyc == s0 + 80) || (cyc == s0 + 162);
            if (cyc == s0 + 162) busy_in_done = bus_a.busy;
            if (cyc == s0 + 163) busy_after = bus_a.busy;
            tick(1);
        end
        bus_a.start = 1'b0;
        chk("t3_done_cyc", 32'(done_cyc_a - s0), 32'd162);
        chk("t3_busy_in_done", 32'(busy_in_done), 32'd1);
        chk("t3_busy_after", 32'(busy_after), 32'd0);
        chk("t3_no_restart", 32'(bus_a.busy), 32'd0);
        chk("t3_done_once", 32'(done_cnt_a - bd), 32'd1);
        check_stream("t3", bb);

        // T4: reset while x7 byte 2 is on the wire
        regs_a[7] = 32'hC0DE_7A55;
        s0 = cyc;
        pulse_start_a();
        while (cyc < s0 + 40) tick(1);
        chk("t4_pre_valid", 32'(bus_a.tx_valid), 32'd1);
        chk("t4_pre_data", 32'(bus_a.tx_data), 32'h0000_007A);
        chk("t4_pre_addr", 32'(bus_a.rd_address), 32'd7);
        reset = 1'b1;
        tick(1);
        chk("t4_valid", 32'(bus_a.tx_valid), 32'd0);
        chk("t4_busy", 32'(bus_a.busy), 32'd0);
        chk("t4_halt", 32'(bus_a.halt_req), 32'd0);
        chk("t4_addr", 32'(bus_a.rd_address), 32'd0);
        reset = 1'b0;
        tick(2);
        bb = bytes_a.size(); bd = done_cnt_a; s0 = cyc;
        pulse_start_a();
        wait_done(1'b0, bd, 400, "t4_done_seen");
        chk("t4_done_cyc", 32'(done_cyc_a - s0), 32'd162);
        check_stream("t4", bb);
        tick(3);

        // T6: garbage on rd_data outside the fetch cycle
        garbage_en = 1'b1;
        bb = bytes_a.size(); bd = done_cnt_a; ba = addr_seq.size();
        pulse_start_a();
        wait_done(1'b0, bd, 400, "t6_done_seen");
        tick(2);
        check_stream("t6", bb);
        chk("t6_addr_count", 32'(addr_seq.size() - ba), 32'd32);
        for (int i = 0; i < 32; i++) begin
            if (ba + i < addr_seq.size()) chk($sformatf("t6_addr%0d", i), 32'(addr_seq[ba + i]), 32'(i));
        end
        chk("t6_addr_idle", 32'(bus_a.rd_address), 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_addr_rst", 32'(bus_a.rd_address), 32'd0);
        garbage_en = 1'b0;
        tick(2);

        // T5: 4 registers, no header
        bb = bytes_b.size(); bd = done_cnt_b; s0 = cyc;
        bus_b.start = 1'b1;
        tick(1);
        bus_b.start = 1'b0;
        wait_done(1'b1, bd, 100, "t5_done_seen");
        chk("t5_done_cyc", 32'(done_cyc_b - s0), 32'd21);
        chk("t5_count", 32'(bytes_b.size() - bb), 32'd16);
        if (bytes_b.size() - bb == 16) begin
            for (int i = 0; i < 15; i++) chk($sformatf("t5_byte%0d", i), 32'(bytes_b[bb + i]), 32'd0);
            chk("t5_last", 32'(bytes_b[bb + 15]), 32'h0000_00FF);
        end
        tick(1);
        chk("t5_busy_after", 32'(bus_b.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
